// File: rtl/elevator_call_panel.sv
// SCAN call panel: latches button presses and issues one-hot targets to the elevator controller.
// Optional travel watchdog is compiled in with `define CALL_TIMEOUT_EN.
module elevator_call_panel #(
  parameter int NUM_FLOORS     = 5,
  parameter int DWELL_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] btn,
  input  logic [NUM_FLOORS-1:0] floor_pos,
  output logic [NUM_FLOORS-1:0] floor_req,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open,
  output logic                  busy,
  output logic                  fault
);
  localparam int IDX_W = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
  localparam int DW_W  = $clog2(DWELL_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SELECT, TRAVEL, DWELL} state_t;

  state_t                state, state_nxt;
  logic [NUM_FLOORS-1:0] pending_nxt, req_nxt, tgt_mask, latch_mask;
  logic [IDX_W-1:0]      cur_floor, cur_nxt, tgt, tgt_nxt;
  logic [IDX_W-1:0]      pos_idx, up_idx, dn_idx, sel_idx;
  logic                  pos_onehot, up_found, dn_found, sel_dir;
  logic                  dir_up, dir_nxt, door_nxt;
  logic [DW_W-1:0]       dwell_cnt, dwell_nxt;

`ifdef CALL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt, wd_nxt;
  logic            fault_nxt;
`else
  // no watchdog in this build: constant 0
  assign fault = (TIMEOUT_CYCLES < 0);
`endif

  assign busy     = (state != IDLE);
  assign tgt_mask = NUM_FLOORS'(1) << tgt;

  // Car position decode and SCAN candidate search
  always_comb begin
    pos_idx  = '0;
    up_idx   = '0;
    dn_idx   = '0;
    up_found = 1'b0;
    dn_found = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (floor_pos[i]) pos_idx = IDX_W'(i);
    pos_onehot = (floor_pos != '0) &&
                 ((floor_pos & (floor_pos - NUM_FLOORS'(1))) == '0);
    cur_nxt = pos_onehot ? pos_idx : cur_floor;
    // descending scan leaves the nearest floor above in up_idx
    for (int i = NUM_FLOORS - 1; i >= 0; i--)
      if (pending[i] && (i > int'(cur_floor))) begin
        up_found = 1'b1;
        up_idx   = IDX_W'(i);
      end
    for (int i = 0; i < NUM_FLOORS; i++)
      if (pending[i] && (i < int'(cur_floor))) begin
        dn_found = 1'b1;
        dn_idx   = IDX_W'(i);
      end
    sel_idx = up_idx;
    sel_dir = 1'b1;
    if (pending[cur_floor]) begin
      sel_idx = cur_floor;
      sel_dir = dir_up;
    end else if (dir_up && up_found) begin
      sel_idx = up_idx;
      sel_dir = 1'b1;
    end else if (dn_found) begin
      sel_idx = dn_idx;
      sel_dir = 1'b0;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    latch_mask  = ((state == TRAVEL) || (state == DWELL)) ? tgt_mask : '0;
    pending_nxt = pending | (btn & ~latch_mask);
    state_nxt   = state;
    req_nxt     = floor_req;
    door_nxt    = door_open;
    dir_nxt     = dir_up;
    tgt_nxt     = tgt;
    dwell_nxt   = dwell_cnt;
`ifdef CALL_TIMEOUT_EN
    wd_nxt    = wd_cnt;
    fault_nxt = fault;
`endif
    case (state)
      IDLE: if (pending != '0) state_nxt = SELECT;
      SELECT: begin
        tgt_nxt   = sel_idx;
        dir_nxt   = sel_dir;
        req_nxt   = NUM_FLOORS'(1) << sel_idx;
        state_nxt = TRAVEL;
`ifdef CALL_TIMEOUT_EN
        wd_nxt = '0;
`endif
      end
      TRAVEL: begin
        if (floor_pos == floor_req) begin
          req_nxt     = '0;
          pending_nxt = pending_nxt & ~tgt_mask;
          door_nxt    = 1'b1;
          dwell_nxt   = DW_W'(DWELL_CYCLES);
          state_nxt   = DWELL;
        end
`ifdef CALL_TIMEOUT_EN
        else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
          req_nxt     = '0;
          pending_nxt = pending_nxt & ~tgt_mask;
          fault_nxt   = 1'b1;
          state_nxt   = IDLE;
        end else begin
          wd_nxt = wd_cnt + WD_W'(1);
        end
`endif
      end
      DWELL: begin
        if (dwell_cnt <= DW_W'(1)) begin
          door_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          dwell_nxt = dwell_cnt - DW_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= '0;
      floor_req <= '0;
      door_open <= 1'b0;
      dir_up    <= 1'b1;
      cur_floor <= '0;
      tgt       <= '0;
      dwell_cnt <= '0;
`ifdef CALL_TIMEOUT_EN
      wd_cnt    <= '0;
      fault     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      floor_req <= req_nxt;
      door_open <= door_nxt;
      dir_up    <= dir_nxt;
      cur_floor <= cur_nxt;
      tgt       <= tgt_nxt;
      dwell_cnt <= dwell_nxt;
`ifdef CALL_TIMEOUT_EN
      wd_cnt    <= wd_nxt;
      fault     <= fault_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed bench for elevator_call_panel: SCAN order, latency, dwell, absorb, reset and watchdog.
module tb_elevator_call_panel;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn, floor_pos, floor_req, pending;
  logic       door_open, busy, fault;
  int         total = 0;
  int         bad = 0;

  elevator_call_panel dut (
    .clk(clk), .reset(reset), .btn(btn), .floor_pos(floor_pos),
    .floor_req(floor_req), .pending(pending), .door_open(door_open),
    .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on the arrival edge: door stays high 3 more cycles, then drops with busy.
  task automatic check_dwell(input string tag);
    for (int k = 0; k < 3; k++) begin
      step();
      check({tag, "_door_hi"}, door_open, 1);
    end
    step();
    check({tag, "_door_lo"}, door_open, 0);
    check({tag, "_busy_lo"}, busy, 0);
  endtask

  initial begin
    reset = 1'b1; btn = '0; floor_pos = 5'b00001;
    step(); step();
    reset = 1'b0;
    check("rst_req", floor_req, 0);
    check("rst_pend", pending, 0);
    check("rst_door", door_open, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_dir", dut.dir_up, 1);

    // single call to floor 3
    btn = 5'b00100; step(); btn = '0;
    check("t1_pend", pending, 5'b00100);
    check("t1_idle", busy, 0);
    step();
    check("t1_sel_req", floor_req, 0);
    check("t1_sel_busy", busy, 1);
    step();
    check("t1_req", floor_req, 5'b00100);
    step();
    check("t1_req_hold", floor_req, 5'b00100);
    floor_pos = 5'b00100; step();
    check("t1_arr_req", floor_req, 0);
    check("t1_arr_door", door_open, 1);
    check("t1_arr_pend", pending, 0);
    check_dwell("t1");

    // car at floor 3, going up: floor 5 before floor 2
    btn = 5'b10010; step(); btn = '0;
    check("t2_pend", pending, 5'b10010);
    step(); step();
    check("t2_req5", floor_req, 5'b10000);
    check("t2_dir_up", dut.dir_up, 1);
    floor_pos = 5'b10000; step();
    check("t2_arr5_pend", pending, 5'b00010);
    check_dwell("t2a");
    step(); step();
    check("t2_req2", floor_req, 5'b00010);
    check("t2_dir_dn", dut.dir_up, 0);
    floor_pos = 5'b00010; step();
    check("t2_arr2_pend", pending, 0);
    check_dwell("t2b");

    // call for the current floor while idle
    floor_pos = 5'b00001; step();
    btn = 5'b00001; step(); btn = '0;
    step(); step();
    check("t3_req", floor_req, 5'b00001);
    step();
    check("t3_req_1cyc", floor_req, 0);
    check("t3_door", door_open, 1);
    check_dwell("t3");

    // repeat press of active target absorbed; bad positions ignored
    btn = 5'b01000; step(); btn = '0;
    step(); step();
    check("t4_req", floor_req, 5'b01000);
    btn = 5'b01000; step(); btn = '0;
    check("t4_absorb", pending, 5'b01000);
    floor_pos = 5'b00000; step();
    check("t4_zero_req", floor_req, 5'b01000);
    check("t4_zero_door", door_open, 0);
    floor_pos = 5'b00110; step();
    check("t4_multi_req", floor_req, 5'b01000);
    check("t4_cur_held", dut.cur_floor, 0);
    floor_pos = 5'b01000; step();
    check("t4_arr_pend", pending, 0);
    btn = 5'b01000; step(); btn = '0;
    check("t4_dwell_absorb", pending, 0);
    step(); step();
    check("t4_door_last", door_open, 1);
    step();
    check("t4_door_lo", door_open, 0);
    step();
    check("t4_once_busy", busy, 0);
    check("t4_once_req", floor_req, 0);

    // reset during dwell with other calls pending
    btn = 5'b00100; step(); btn = '0;
    step(); step();
    check("t5_req", floor_req, 5'b00100);
    btn = 5'b10001; step(); btn = '0;
    check("t5_pend3", pending, 5'b10101);
    floor_pos = 5'b00100; step();
    check("t5_dwell_pend", pending, 5'b10001);
    check("t5_dwell_door", door_open, 1);
    check("t5_dir_before", dut.dir_up, 0);
    reset = 1'b1; step(); reset = 1'b0;
    check("t5_rst_pend", pending, 0);
    check("t5_rst_door", door_open, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_req", floor_req, 0);
    check("t5_rst_dir", dut.dir_up, 1);
    step();
    check("t5_stay_idle", busy, 0);

`ifdef CALL_TIMEOUT_EN
    // watchdog: car never moves
    begin
      logic door_seen;
      door_seen = 1'b0;
      floor_pos = 5'b00001; step();
      btn = 5'b10000; step(); btn = '0;
      step(); step();
      check("t6_req", floor_req, 5'b10000);
      for (int k = 0; k < 254; k++) begin
        step();
        door_seen = door_seen | door_open;
      end
      check("t6_pre_fault", fault, 0);
      check("t6_pre_req", floor_req, 5'b10000);
      step();
      door_seen = door_seen | door_open;
      check("t6_fault", fault, 1);
      check("t6_req_clr", floor_req, 0);
      check("t6_pend_clr", pending, 0);
      check("t6_busy", busy, 0);
      step(); step();
      check("t6_sticky", fault, 1);
      check("t6_no_door", door_seen, 0);
    end
`else
    check("t6_fault_tied", fault, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
